// File: rtl/store_write_buffer.sv
// Store buffer: queues LSU stores and issues them one at a time to the AXI write master.
// Flags loads hitting a pending store's 8-byte word and latches a sticky write error.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int WR_ID  = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    input  logic [1:0]               st_size,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_conflict,
    output logic                     wm_aw_valid,
    input  logic                     wm_ready,
    output logic [ID_W-1:0]          wm_id,
    output logic [ADDR_W-1:0]        wm_addr,
    output logic [7:0]               wm_len,
    output logic [1:0]               wm_size,
    output logic [DATA_W-1:0]        wm_data,
    input  logic [1:0]               wm_resp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty_idle,
    output logic                     bw_err,
    input  logic                     err_clr
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [PW:0]         wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [1:0]          size_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];

    logic                full, empty, push, pop;
    logic [PW-1:0]       head, off;
    logic [5:0]          shamt;
    logic [DATA_W-1:0]   st_shifted;
    logic                unused_ld_low;

    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) &&
                   (wr_ptr[PW] != rd_ptr[PW]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign head  = rd_ptr[PW-1:0];

    assign st_ready = !full;
    assign push     = st_valid && st_ready;

    // Data is stored already lane-aligned; bytes past the top lane are dropped.
    assign shamt      = {st_addr[2:0], 3'b000};
    assign st_shifted = st_data << shamt;

    assign wm_id   = ID_W'(WR_ID);
    assign wm_len  = 8'd0;
    assign wm_addr = addr_q[head];
    assign wm_size = size_q[head];
    assign wm_data = data_q[head];

    assign empty_idle    = empty && (state_q == S_IDLE);
    assign unused_ld_low = ^ld_addr[2:0];

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr[PW-1:0]] <= st_addr;
            size_q[wr_ptr[PW-1:0]] <= st_size;
            data_q[wr_ptr[PW-1:0]] <= st_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            state_q <= S_IDLE;
            bw_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pop && (wm_resp != 2'b00))
                bw_err <= 1'b1;
            else if (err_clr)
                bw_err <= 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        wm_aw_valid = 1'b0;
        pop         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && wm_ready) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                wm_aw_valid = 1'b1;
                if (wm_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wm_ready) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slot i is occupied when its distance from the head is below count.
    always_comb begin
        ld_conflict = 1'b0;
        off         = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head;
            if (({1'b0, off} < count) &&
                (addr_q[i][ADDR_W-1:3] == ld_addr[ADDR_W-1:3]))
                ld_conflict = 1'b1;
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with hand-computed expectations.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        wm_aw_valid;
    logic        wm_ready;
    logic [3:0]  wm_id;
    logic [31:0] wm_addr;
    logic [7:0]  wm_len;
    logic [1:0]  wm_size;
    logic [63:0] wm_data;
    logic [1:0]  wm_resp;
    logic [2:0]  count;
    logic        empty_idle;
    logic        bw_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_write_buffer dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .wm_aw_valid(wm_aw_valid), .wm_ready(wm_ready),
        .wm_id(wm_id), .wm_addr(wm_addr), .wm_len(wm_len),
        .wm_size(wm_size), .wm_data(wm_data), .wm_resp(wm_resp),
        .count(count), .empty_idle(empty_idle),
        .bw_err(bw_err), .err_clr(err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [1:0] sz,
                        input logic [63:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_size  = sz;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        ld_addr  = 32'hFFFF_FFF8;
        wm_ready = 1'b1;
        wm_resp  = 2'b00;
        err_clr  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst_count", 64'(count), 64'd0);
        check("rst_st_ready", 64'(st_ready), 64'd1);
        check("rst_aw_valid", 64'(wm_aw_valid), 64'd0);
        check("rst_empty_idle", 64'(empty_idle), 64'd1);
        check("rst_bw_err", 64'(bw_err), 64'd0);
        check("rst_ld_conflict", 64'(ld_conflict), 64'd0);

        // Single store, master idle throughout issue
        push(32'h8000_0004, 2'b10, 64'hDEAD_BEEF);
        check("s1_count", 64'(count), 64'd1);
        check("s1_valid_early", 64'(wm_aw_valid), 64'd0);
        check("s1_not_idle", 64'(empty_idle), 64'd0);
        step();
        check("s1_valid", 64'(wm_aw_valid), 64'd1);
        check("s1_data", wm_data, 64'hDEAD_BEEF_0000_0000);
        check("s1_addr", 64'(wm_addr), 64'h8000_0004);
        check("s1_size", 64'(wm_size), 64'd2);
        check("s1_id", 64'(wm_id), 64'd1);
        check("s1_len", 64'(wm_len), 64'd0);
        step();
        wm_ready = 1'b0;
        check("s1_wait_valid", 64'(wm_aw_valid), 64'd0);
        step();
        check("s1_wait_count", 64'(count), 64'd1);
        check("s1_wait_data", wm_data, 64'hDEAD_BEEF_0000_0000);
        wm_ready = 1'b1;
        step();
        check("s1_pop_count", 64'(count), 64'd0);
        check("s1_empty_idle", 64'(empty_idle), 64'd1);

        // Load hazard against a pending byte store
        wm_ready = 1'b0;
        push(32'h8000_0103, 2'b00, 64'hAA);
        ld_addr = 32'h8000_0100;
        #1;
        check("hz_hit", 64'(ld_conflict), 64'd1);
        check("hz_data", wm_data, 64'h0000_0000_AA00_0000);
        ld_addr = 32'h8000_0108;
        #1;
        check("hz_miss", 64'(ld_conflict), 64'd0);
        ld_addr = 32'h8000_0100;
        wm_ready = 1'b1;
        step();
        check("hz_inflight", 64'(ld_conflict), 64'd1);
        step();
        step();
        check("hz_pop_count", 64'(count), 64'd0);
        check("hz_after_pop", 64'(ld_conflict), 64'd0);

        // Fill with master busy, then drain in order
        wm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h10 + 32'(i * 8), 2'b11, 64'(i));
            check("fill_count", 64'(count), 64'(i + 1));
        end
        check("fill_st_ready", 64'(st_ready), 64'd0);
        push(32'h30, 2'b11, 64'd9);
        check("fill_stall", 64'(count), 64'd4);
        wm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_valid", 64'(wm_aw_valid), 64'd1);
            check("drain_addr", 64'(wm_addr), 64'h10 + 64'(i * 8));
            step();
            step();
            check("drain_count", 64'(count), 64'(3 - i));
        end
        check("drain_idle", 64'(empty_idle), 64'd1);

        // Simultaneous push and pop at count 2
        wm_ready = 1'b0;
        push(32'h40, 2'b11, 64'd1);
        push(32'h48, 2'b11, 64'd2);
        wm_ready = 1'b1;
        step();
        check("pp_head", 64'(wm_addr), 64'h40);
        step();
        st_valid = 1'b1;
        st_addr  = 32'h50;
        st_data  = 64'd3;
        st_size  = 2'b11;
        step();
        st_valid = 1'b0;
        check("pp_count", 64'(count), 64'd2);
        step();
        check("pp_second", 64'(wm_addr), 64'h48);
        step();
        step();
        check("pp_count1", 64'(count), 64'd1);
        step();
        check("pp_third", 64'(wm_addr), 64'h50);
        step();
        step();
        check("pp_count0", 64'(count), 64'd0);

        // Error response handling
        wm_ready = 1'b0;
        push(32'h80, 2'b11, 64'd5);
        wm_resp  = 2'b10;
        wm_ready = 1'b1;
        step();
        step();
        step();
        check("err_set", 64'(bw_err), 64'd1);
        wm_resp = 2'b00;
        step();
        check("err_sticky", 64'(bw_err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", 64'(bw_err), 64'd0);
        wm_ready = 1'b0;
        push(32'h88, 2'b11, 64'd6);
        wm_ready = 1'b1;
        step();
        step();
        wm_resp = 2'b10;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        wm_resp = 2'b00;
        check("err_set_wins", 64'(bw_err), 64'd1);

        // Reset while waiting on the master with three entries queued
        wm_ready = 1'b0;
        push(32'h60, 2'b11, 64'd7);
        push(32'h68, 2'b11, 64'd8);
        push(32'h70, 2'b11, 64'd9);
        ld_addr  = 32'h60;
        wm_ready = 1'b1;
        step();
        step();
        wm_ready = 1'b0;
        check("mr_count_pre", 64'(count), 64'd3);
        check("mr_conflict_pre", 64'(ld_conflict), 64'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mr_count", 64'(count), 64'd0);
        check("mr_aw_valid", 64'(wm_aw_valid), 64'd0);
        check("mr_bw_err", 64'(bw_err), 64'd0);
        check("mr_conflict", 64'(ld_conflict), 64'd0);
        check("mr_empty_idle", 64'(empty_idle), 64'd1);
        check("mr_st_ready", 64'(st_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
